ctr_xor_engine: RTL and testbench

CTR_XOR_ENGINE -- requirements
Module: ctr_xor_engine

---
 rtl/ccm_pkg.sv | 13 +
 rtl/ccm_ctr_gen.sv | 43 ++++
 rtl/ctr_xor_engine.sv | 150 +++++++++++++++
 tb/tb_ctr_xor_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccm_pkg.sv
// Shared definitions for the CTR-mode XOR engine: block width and FSM state encoding.
package ccm_pkg;

    localparam int unsigned BLOCK_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STREAM,
        DRAIN
    } state_t;

endpackage

// File: rtl/ccm_ctr_gen.sv
// Counter-block generator: latches flag/nonce, owns the block counter and its sticky wrap flag.
module ccm_ctr_gen
    import ccm_pkg::*;
#(
    parameter int unsigned WIDTH_FLAG  = 8,
    parameter int unsigned WIDTH_NONCE = 104,
    parameter int unsigned WIDTH_COUNT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   inc,
    input  logic [WIDTH_FLAG-1:0]  flag,
    input  logic [WIDTH_NONCE-1:0] nonce,
    output logic [BLOCK_WIDTH-1:0] block,
    output logic                   wrap
);

    logic [WIDTH_FLAG-1:0]  flag_q;
    logic [WIDTH_NONCE-1:0] nonce_q;
    logic [WIDTH_COUNT-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q  <= '0;
            nonce_q <= '0;
            count_q <= WIDTH_COUNT'(1);
            wrap    <= 1'b0;
        end else if (load) begin
            flag_q  <= flag;
            nonce_q <= nonce;
            count_q <= WIDTH_COUNT'(1);
        end else if (inc) begin
            count_q <= count_q + WIDTH_COUNT'(1);
            // wrap is sticky across messages; only reset clears it
            if (&count_q)
                wrap <= 1'b1;
        end
    end

    assign block = {flag_q, nonce_q, count_q};

endmodule

// File: rtl/ctr_xor_engine.sv
// CTR-mode XOR engine: fetches keystream blocks from an external AES core and XORs them onto a byte-length-bounded lane stream.
module ctr_xor_engine
    import ccm_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned WIDTH_NONCE = 104,
    parameter int unsigned WIDTH_FLAG  = 8,
    parameter int unsigned WIDTH_COUNT = 16,
    parameter int unsigned WIDTH_LEN   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH_LEN-1:0]   msg_length,
    input  logic [WIDTH_NONCE-1:0] ctr_nonce,
    input  logic [WIDTH_FLAG-1:0]  ctr_flag,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   ks_req,
    output logic [BLOCK_WIDTH-1:0] ks_block,
    input  logic                   ks_ack,
    input  logic [BLOCK_WIDTH-1:0] ks_data,
    output logic                   busy,
    output logic                   done,
    output logic                   ctr_wrap
);

    localparam int unsigned LANES = BLOCK_WIDTH / WIDTH;
    localparam int unsigned BYTES = WIDTH / 8;

    state_t                 state;
    logic [BLOCK_WIDTH-1:0] ks_q;
    logic [4:0]             lane_q;
    logic [WIDTH_LEN-1:0]   remaining;
    logic [BLOCK_WIDTH-1:0] ctr_block;
    logic [WIDTH-1:0]       lane_mask;
    logic                   ctr_load;
    logic                   ctr_inc;
    logic                   accept;
    logic                   final_lane;

    assign ctr_load   = (state == IDLE) && start && (msg_length != '0);
    assign ctr_inc    = ks_req && ks_ack;
    assign in_ready   = (state == STREAM) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign final_lane = (remaining <= WIDTH_LEN'(BYTES));
    assign busy       = (state != IDLE);
    assign ks_block   = ks_req ? ctr_block : '0;

    // Byte 0 of a lane is its most-significant byte; bytes at or past the message end are zeroed.
    always_comb begin
        lane_mask = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (WIDTH_LEN'(b) < remaining)
                lane_mask[WIDTH-1-8*b -: 8] = 8'hFF;
        end
    end

    ccm_ctr_gen #(
        .WIDTH_FLAG  (WIDTH_FLAG),
        .WIDTH_NONCE (WIDTH_NONCE),
        .WIDTH_COUNT (WIDTH_COUNT)
    ) u_ctr_gen (
        .clk   (clk),
        .reset (reset),
        .load  (ctr_load),
        .inc   (ctr_inc),
        .flag  (ctr_flag),
        .nonce (ctr_nonce),
        .block (ctr_block),
        .wrap  (ctr_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ks_q      <= '0;
            lane_q    <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ks_req    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            // A taken output frees the register; a same-cycle accept below overrides this.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (msg_length == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= msg_length;
                            lane_q    <= '0;
                            ks_req    <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (ks_req && ks_ack) begin
                        ks_q   <= ks_data;
                        ks_req <= 1'b0;
                        lane_q <= '0;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        out_data  <= (in_data ^ ks_q[BLOCK_WIDTH-1 -: WIDTH]) & lane_mask;
                        out_valid <= 1'b1;
                        out_last  <= final_lane;
                        if (final_lane) begin
                            remaining <= '0;
                            ks_q      <= '0;
                            state     <= DRAIN;
                        end else begin
                            remaining <= remaining - WIDTH_LEN'(BYTES);
                            ks_q      <= ks_q << WIDTH;
                            if (lane_q == 5'(LANES - 1)) begin
                                ks_req <= 1'b1;
                                state  <= REQ;
                            end else begin
                                lane_q <= lane_q + 5'd1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_xor_engine.sv
// Directed scoreboard bench for ctr_xor_engine at WIDTH=8, WIDTH=32 and a 2-bit counter variant.
module tb_ctr_xor_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, out_ready, ks_ack;
    logic         start_a, start_b, start_c;
    logic [15:0]  msg_length;
    logic [7:0]   ctr_flag;
    logic [103:0] ctr_nonce;
    logic [31:0]  in_data;
    logic [127:0] ks_data;

    logic         a_in_ready, a_out_valid, a_out_last, a_ks_req, a_busy, a_done, a_wrap;
    logic [7:0]   a_out_data;
    logic [127:0] a_ks_block;
    logic         b_in_ready, b_out_valid, b_out_last, b_ks_req, b_busy, b_done, b_wrap;
    logic [31:0]  b_out_data;
    logic [127:0] b_ks_block;
    logic         c_in_ready, c_out_valid, c_out_last, c_ks_req, c_busy, c_done, c_wrap;
    logic [7:0]   c_out_data;
    logic [127:0] c_ks_block;

    ctr_xor_engine #(.WIDTH(8)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .msg_length(msg_length),
        .ctr_nonce(ctr_nonce), .ctr_flag(ctr_flag), .in_data(in_data[7:0]), .in_valid(in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_last(a_out_last), .ks_req(a_ks_req), .ks_block(a_ks_block), .ks_ack(ks_ack),
        .ks_data(ks_data), .busy(a_busy), .done(a_done), .ctr_wrap(a_wrap));

    ctr_xor_engine #(.WIDTH(32)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .msg_length(msg_length),
        .ctr_nonce(ctr_nonce), .ctr_flag(ctr_flag), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_last(b_out_last), .ks_req(b_ks_req), .ks_block(b_ks_block), .ks_ack(ks_ack),
        .ks_data(ks_data), .busy(b_busy), .done(b_done), .ctr_wrap(b_wrap));

    ctr_xor_engine #(.WIDTH(8), .WIDTH_NONCE(118), .WIDTH_COUNT(2)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .msg_length(msg_length),
        .ctr_nonce({14'h0, ctr_nonce}), .ctr_flag(ctr_flag), .in_data(in_data[7:0]), .in_valid(in_valid),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_last(c_out_last), .ks_req(c_ks_req), .ks_block(c_ks_block), .ks_ack(ks_ack),
        .ks_data(ks_data), .busy(c_busy), .done(c_done), .ctr_wrap(c_wrap));

    int           sel = 0;
    logic         obs_in_ready, obs_out_valid, obs_out_last, obs_ks_req, obs_busy, obs_done, obs_wrap;
    logic [31:0]  obs_out_data;
    logic [127:0] obs_ks_block;

    always_comb begin
        obs_in_ready = a_in_ready;  obs_out_valid = a_out_valid; obs_out_last = a_out_last;
        obs_ks_req   = a_ks_req;    obs_busy = a_busy; obs_done = a_done; obs_wrap = a_wrap;
        obs_out_data = 32'(a_out_data); obs_ks_block = a_ks_block;
        case (sel)
            1: begin
                obs_in_ready = b_in_ready;  obs_out_valid = b_out_valid; obs_out_last = b_out_last;
                obs_ks_req   = b_ks_req;    obs_busy = b_busy; obs_done = b_done; obs_wrap = b_wrap;
                obs_out_data = b_out_data;  obs_ks_block = b_ks_block;
            end
            2: begin
                obs_in_ready = c_in_ready;  obs_out_valid = c_out_valid; obs_out_last = c_out_last;
                obs_ks_req   = c_ks_req;    obs_busy = c_busy; obs_done = c_done; obs_wrap = c_wrap;
                obs_out_data = 32'(c_out_data); obs_ks_block = c_ks_block;
            end
            default: ;
        endcase
    end

    int           checks = 0, errors = 0;
    int           cur_w, cur_bytes, n_lanes, lane_next, lanes_out, n_req, cyc;
    int           ks_delay = 0, ks_wait = 0, ready_mode = 0;
    logic         poke = 1'b0, exp_done = 1'b0, was_stall = 1'b0;
    logic [15:0]  cur_len, exp_ctr, ctr_mask;
    logic         exp_wrap [3];
    logic [127:0] ks_val;
    logic [31:0]  prev_data;
    logic [31:0]  exp_data_q [$];
    logic         exp_last_q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gen_in(input int i);
        logic [31:0] v = '0;
        for (int b = 0; b < cur_bytes; b++)
            v[(cur_bytes-1-b)*8 +: 8] = 8'(i*cur_bytes + b);
        return v;
    endfunction

    // Keystream lane i of a block is the i-th WIDTH slice counted from the MSB.
    function automatic logic [31:0] model(input int i, input logic [31:0] din);
        logic [127:0] t;
        logic [31:0]  r;
        t = ks_val << ((i % (128/cur_w)) * cur_w);
        r = din ^ 32'(t >> (128 - cur_w));
        for (int b = 0; b < cur_bytes; b++)
            if (i*cur_bytes + b >= int'(cur_len))
                r[(cur_bytes-1-b)*8 +: 8] = 8'h00;
        return r;
    endfunction

    function automatic logic [127:0] exp_block();
        if (sel == 2) return {ctr_flag, 14'h0, ctr_nonce, exp_ctr[1:0]};
        return {ctr_flag, ctr_nonce, exp_ctr};
    endfunction

    task automatic set_start(input logic v);
        start_a = (sel == 0) && v;
        start_b = (sel == 1) && v;
        start_c = (sel == 2) && v;
    endtask

    // Keystream responder: checks each request's block, optionally delays, then acks once.
    initial begin
        ks_ack = 1'b0; ks_data = '0;
        forever begin
            @(negedge clk); #2;
            if (obs_ks_req && !ks_ack) begin
                chk("ks_block", obs_ks_block, exp_block());
                if (ks_wait < ks_delay) begin
                    ks_wait++;
                end else begin
                    ks_wait = 0;
                    chk("ctr_wrap", obs_wrap, exp_wrap[sel]);
                    ks_ack = 1'b1; ks_data = ks_val; n_req++;
                    if (exp_ctr == ctr_mask) exp_wrap[sel] = 1'b1;
                    exp_ctr = (exp_ctr + 16'd1) & ctr_mask;
                end
            end else begin
                ks_ack = 1'b0; ks_data = '0;
            end
        end
    end

    task automatic step();
        logic [31:0] d;
        logic        l;
        @(negedge clk);
        out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
        set_start(poke && cyc == 3);
        if (poke && cyc == 3) msg_length = 16'd1;
        in_valid = (lane_next < n_lanes);
        in_data  = gen_in(lane_next);
        #1;
        chk("done", obs_done, exp_done);
        exp_done = 1'b0;
        if (was_stall) begin
            chk("hold_valid", obs_out_valid, 1'b1);
            chk("hold_data", obs_out_data, prev_data);
        end
        if (obs_out_valid && !out_ready) chk("in_ready_stall", obs_in_ready, 1'b0);
        if (lane_next >= n_lanes) chk("in_ready_after_final", obs_in_ready, 1'b0);
        if (in_valid && obs_in_ready) begin
            exp_data_q.push_back(model(lane_next, in_data));
            exp_last_q.push_back((lane_next + 1) * cur_bytes >= int'(cur_len));
            lane_next++;
        end
        if (obs_out_valid && out_ready) begin
            if (exp_data_q.size() == 0) begin
                checks++; errors++;
                $error("FAIL unexpected_lane: observed %0h expected none", obs_out_data);
            end else begin
                d = exp_data_q.pop_front();
                l = exp_last_q.pop_front();
                chk("out_data", obs_out_data, d);
                chk("out_last", obs_out_last, l);
                lanes_out++;
                if (l) exp_done = 1'b1;
            end
        end
        was_stall = obs_out_valid && !out_ready;
        prev_data = obs_out_data;
        cyc++;
    endtask

    task automatic begin_msg(input int s, input int len, input int mode, input int delay, input logic pk);
        sel = s; cur_w = (s == 1) ? 32 : 8; cur_bytes = cur_w / 8;
        cur_len = 16'(len); n_lanes = (len + cur_bytes - 1) / cur_bytes;
        ready_mode = mode; ks_delay = delay; ks_wait = 0; poke = pk;
        lane_next = 0; lanes_out = 0; n_req = 0; cyc = 0;
        exp_ctr = 16'd1; ctr_mask = (s == 2) ? 16'h0003 : 16'hFFFF;
        exp_done = 1'b0; was_stall = 1'b0;
        exp_data_q.delete(); exp_last_q.delete();
        @(negedge clk);
        msg_length = 16'(len); ctr_flag = 8'h59 + 8'(s);
        ctr_nonce = {26{4'(len)}} ^ 104'hA5A5_0F0F_1234_5678_9ABC_DEF0_11;
        in_valid = 1'b0; out_ready = 1'b1;
        set_start(1'b1);
    endtask

    task automatic run_msg(input int s, input int len, input int mode, input int delay,
                           input logic pk, input int exp_req);
        begin_msg(s, len, mode, delay, pk);
        while (!(lanes_out == n_lanes && !obs_busy) && cyc < 2000) step();
        chk("timeout", cyc < 2000, 1'b1);
        chk("lane_count", lanes_out, n_lanes);
        chk("ks_req_count", n_req, exp_req);
        chk("ctr_wrap_end", obs_wrap, exp_wrap[s]);
        in_valid = 1'b0;
    endtask

    task automatic check_idle();
        chk("rst_in_ready", obs_in_ready, 1'b0);
        chk("rst_out_valid", obs_out_valid, 1'b0);
        chk("rst_out_last", obs_out_last, 1'b0);
        chk("rst_ks_req", obs_ks_req, 1'b0);
        chk("rst_busy", obs_busy, 1'b0);
        chk("rst_done", obs_done, 1'b0);
        chk("rst_ctr_wrap", obs_wrap, 1'b0);
        chk("rst_out_data", obs_out_data, 32'h0);
        chk("rst_ks_block", obs_ks_block, 128'h0);
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        msg_length = '0; ctr_flag = '0; ctr_nonce = '0; ks_val = '0;
        for (int i = 0; i < 3; i++) exp_wrap[i] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check_idle();
        end

        // Single block, all-ones keystream: outputs FF..F0.
        ks_val = '1;
        run_msg(0, 16, 0, 0, 1'b0, 1);

        ks_val = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        run_msg(0, 20, 0, 0, 1'b0, 2);
        run_msg(1, 6, 0, 0, 1'b0, 1);
        // Back-pressure, slow keystream and a start pulse that must be ignored mid-message.
        run_msg(0, 20, 1, 2, 1'b1, 2);
        run_msg(1, 37, 1, 1, 1'b0, 3);
        run_msg(2, 64, 0, 0, 1'b0, 4);

        // Reset mid-message, then a zero-length start.
        begin_msg(0, 20, 0, 0, 1'b0);
        while (lane_next < 5 && cyc < 200) step();
        chk("timeout_mid", cyc < 200, 1'b1);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) exp_wrap[i] = 1'b0;
        exp_data_q.delete(); exp_last_q.delete();
        #1;
        check_idle();
        sel = 2; #1;
        chk("rst_wrap_c", obs_wrap, 1'b0);
        sel = 0;
        @(negedge clk);
        msg_length = 16'd0; set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        #1;
        chk("zero_len_done", obs_done, 1'b1);
        chk("zero_len_busy", obs_busy, 1'b0);
        chk("zero_len_ks_req", obs_ks_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("zero_len_done_end", obs_done, 1'b0);
            chk("zero_len_no_req", obs_ks_req, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
